// File: rtl/osc_freq_meter.sv
// osc_freq_meter: gated edge counter that enables the ring oscillator and measures Tout over a Clk window
// Ports: Clk/Reset (sync, active-high), Start request, Tout async oscillator input;
//        OscEn drives OSC Start, Count/Overflow hold the last result, Valid strobes on update, Busy when not IDLE.
// Optional: define OSC_METER_AVG_EN to average four consecutive windows (Count = sum >> 2).
module osc_freq_meter #(
  parameter int GATE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Tout,
  output logic             OscEn,
  output logic [CNT_W-1:0] Count,
  output logic             Valid,
  output logic             Busy,
  output logic             Overflow
);
  localparam int TMAX = GATE_CYCLES > SETTLE_CYCLES ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx, count_q, count_d;
  logic sat_q, sat_d, sat_nx, ovf_q, ovf_d;
  logic s1_q, s2_q, prev_q, rise;
`ifdef OSC_METER_AVG_EN
  logic [CNT_W+1:0] acc_q, acc_d, acc_sum;
  logic [1:0] win_q, win_d;
`endif
  assign rise   = s2_q & ~prev_q;
  // sat marks that the counter reached all-ones at any point in the run
  assign cnt_nx = (rise && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  assign sat_nx = sat_q | (&cnt_nx);
`ifdef OSC_METER_AVG_EN
  assign acc_sum = acc_q + {2'b00, cnt_nx};
`endif
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    count_d = count_q;
    ovf_d   = ovf_q;
`ifdef OSC_METER_AVG_EN
    acc_d   = acc_q;
    win_d   = win_q;
`endif
    case (state_q)
      IDLE: if (Start) begin
        state_d = SETTLE;
        tmr_d   = TW'(SETTLE_CYCLES - 1);
      end
      SETTLE: if (tmr_q == '0) begin
        state_d = MEASURE;
        tmr_d   = TW'(GATE_CYCLES - 1);
        cnt_d   = '0;
        sat_d   = 1'b0;
`ifdef OSC_METER_AVG_EN
        acc_d   = '0;
        win_d   = '0;
`endif
      end else begin
        tmr_d = tmr_q - TW'(1);
      end
      MEASURE: begin
        cnt_d = cnt_nx;
        sat_d = sat_nx;
        tmr_d = tmr_q - TW'(1);
        if (tmr_q == '0) begin
`ifdef OSC_METER_AVG_EN
          // each window restarts its own saturating count; sat stays sticky across windows
          tmr_d = TW'(GATE_CYCLES - 1);
          cnt_d = '0;
          acc_d = acc_sum;
          win_d = win_q + 2'd1;
          if (win_q == 2'd3) begin
            state_d = DONE;
            count_d = acc_sum[CNT_W+1:2];
            ovf_d   = sat_nx;
          end
`else
          state_d = DONE;
          count_d = cnt_nx;
          ovf_d   = sat_nx;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
`ifdef OSC_METER_AVG_EN
      acc_q   <= '0;
      win_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      s1_q    <= Tout;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
`ifdef OSC_METER_AVG_EN
      acc_q   <= acc_d;
      win_q   <= win_d;
`endif
    end
  end
  assign OscEn    = (state_q == SETTLE) || (state_q == MEASURE);
  assign Busy     = state_q != IDLE;
  assign Valid    = state_q == DONE;
  assign Count    = count_q;
  assign Overflow = ovf_q;
endmodule

// File: tb/tb_osc_freq_meter.sv
// tb_osc_freq_meter: directed scoreboard bench for osc_freq_meter
module tb_osc_freq_meter;
  localparam int G = 100;
  localparam int S = 4;
  localparam int W = 4;
`ifdef OSC_METER_AVG_EN
  localparam int NW = 4;
`else
  localparam int NW = 1;
`endif
  localparam int L = S + NW * G;
  localparam int P = L + 2;
  typedef struct {int cnt; int ovf; int at;} exp_t;
  logic Clk = 0, Reset = 1, Start = 0, Tout = 0;
  logic OscEn, Valid, Busy, Overflow;
  logic [W-1:0] Count;
  int half = 0, cyc = 0, passed = 0, total = 0;
  logic vprev = 0;
  exp_t q[$];
  exp_t e;
  osc_freq_meter #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Tout(Tout), .OscEn(OscEn),
    .Count(Count), .Valid(Valid), .Busy(Busy), .Overflow(Overflow)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  initial forever begin
    @(negedge Clk);
    if (half == 0) Tout = 0;
    else begin
      repeat (half - 1) @(negedge Clk);
      Tout = ~Tout;
    end
  end
  task automatic check(input string n, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d expected %0d", n, act, req);
  endtask
  always @(negedge Clk) begin
    if (Valid && vprev) check("valid_single_cycle", 1, 0);
    if (Valid) begin
      if (q.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        e = q.pop_front();
        check("count", int'(Count), e.cnt);
        check("overflow", int'(Overflow), e.ovf);
        check("valid_cycle", cyc, e.at);
        check("oscen_in_done", int'(OscEn), 0);
      end
    end
    vprev = Valid;
  end
  task automatic run(input int h, input int cnt, input int ovf);
    int oh = 0;
    half = h;
    repeat (30) @(negedge Clk);
    Start = 1;
    @(negedge Clk);
    Start = 0;
    q.push_back('{cnt, ovf, cyc + L});
    repeat (L) begin
      if (OscEn) oh++;
      @(negedge Clk);
    end
    check("oscen_cycles", oh, L);
    check("busy_in_done", int'(Busy), 1);
    @(negedge Clk);
    check("busy_after_done", int'(Busy), 0);
    check("scoreboard_empty", q.size(), 0);
  endtask
  task automatic drain();
    for (int i = 0; i < 2 * P && q.size() != 0; i++) @(negedge Clk);
    check("drain", q.size(), 0);
  endtask
  initial begin
    repeat (3) @(negedge Clk);
    check("rst_oscen", int'(OscEn), 0);
    check("rst_count", int'(Count), 0);
    check("rst_valid", int'(Valid), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_overflow", int'(Overflow), 0);
    Reset = 0;
    run(5, 10, 0);
    run(2, 15, 1);
    run(10, 5, 0);
    run(0, 0, 0);
    half = 5;
    repeat (30) @(negedge Clk);
    Start = 1;
    @(negedge Clk);
    Start = 0;
    repeat (S + 50) @(negedge Clk);
    Reset = 1;
    @(negedge Clk);
    Reset = 0;
    check("mid_rst_oscen", int'(OscEn), 0);
    check("mid_rst_busy", int'(Busy), 0);
    check("mid_rst_count", int'(Count), 0);
    check("mid_rst_overflow", int'(Overflow), 0);
    repeat (L + 10) @(negedge Clk);
    run(5, 10, 0);
    repeat (30) @(negedge Clk);
    Start = 1;
    @(negedge Clk);
    for (int j = 0; j * P < 400; j++) q.push_back('{10, 0, cyc + j * P + L});
    repeat (399) @(negedge Clk);
    Start = 0;
    drain();
    repeat (P) @(negedge Clk);
    check("no_extra_valid", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: bench did not reach summary");
    $fatal(1);
  end
endmodule

// File: doc/osc_freq_meter.md
# osc_freq_meter

Gated frequency counter that sits directly downstream of the OSC ring-oscillator block. It drives the oscillator's Start enable and counts rising edges of the oscillator's asynchronous Tout output over a fixed window of system clocks. It then presents the edge count with a one-cycle valid strobe, so the oscillator can be characterised on-chip without an external counter.

## Interface
Parameters:
- GATE_CYCLES, 1000: length of the measurement window in Clk cycles (≥2).
- SETTLE_CYCLES, 16: Clk cycles between enabling the oscillator and opening the window (≥1).
- CNT_W, 16: width of the edge count.

Ports:
- Clk  in  1  system clock; all logic is on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  measurement request; sampled only in IDLE.
- Tout  in  1  oscillator output, asynchronous to Clk.
- OscEn  out  1  drives OSC Start; high while a measurement is in progress.
- Count  out  CNT_W  last completed edge count; holds until the next completion.
- Valid  out  1  one-cycle strobe; Count was updated this cycle.
- Busy  out  1  high when the state is not IDLE.
- Overflow  out  1  last count saturated; updated together with Count.

## Operation
- Tout passes through a 2-flop synchronizer, then a third flop for edge detection.
  - rise = sync & ~prev.
- FSM states: IDLE, SETTLE, MEASURE, DONE.
- IDLE:
  - Start=1 moves to SETTLE and loads the settle counter.
  - Start=0 stays in IDLE.
- SETTLE:
  - OscEn=1.
  - Lasts exactly SETTLE_CYCLES cycles, then moves to MEASURE.
  - The edge counter is cleared on entry to MEASURE.
- MEASURE:
  - Lasts exactly GATE_CYCLES cycles.
  - Each cycle with rise=1 increments the edge counter.
  - The counter saturates at 2^CNT_W−1 and sets a sticky sat flag.
- DONE:
  - One cycle long.
  - Count, Overflow and Valid are registered on entry.
  - OscEn drops on entry.
  - Next state is IDLE.
- Start is ignored outside IDLE.
- If Start is held high, measurements run back-to-back, with one IDLE cycle between them.
- Tout frequency must be below Clk/2. Higher frequencies undercount; detecting this is out of scope.
- Reset at any point:
  - The next edge forces IDLE.
  - The in-flight measurement is discarded, with no Valid.

## Timing
- Reset values: OscEn=0, Count=0, Valid=0, Busy=0, Overflow=0, FSM=IDLE, synchronizer flops=0.
- Start sampled high at edge k:
  - OscEn and Busy go high in cycle k+1.
  - MEASURE covers cycles k+1+SETTLE_CYCLES through k+SETTLE_CYCLES+GATE_CYCLES.
  - Valid goes high for exactly one cycle, k+SETTLE_CYCLES+GATE_CYCLES+1, with OscEn=0 in that same cycle.
- Busy stays high through the DONE cycle and is low in the following IDLE cycle.
- Synchronizer latency:
  - A Tout edge is counted 3 cycles after it arrives.
  - Edges up to 3 cycles before MEASURE opens can therefore be counted; this is accepted.
  - SETTLE_CYCLES ≥3 keeps a stopped oscillator's startup edge out of the window.
- Edge in the final MEASURE cycle: counted.
- Saturating increment and window close on the same cycle: Count = all-ones and Overflow=1.

## Configuration
- Macro OSC_METER_AVG_EN.
- Defined:
  - MEASURE repeats for 4 consecutive windows, with no settle between them.
  - Edges accumulate in a CNT_W+2-bit accumulator; each window saturates independently.
  - Count = accumulator>>2, truncated.
  - Overflow=1 if any window saturated.
  - Valid appears SETTLE_CYCLES+4·GATE_CYCLES+1 cycles after the Start sample.
- Undefined:
  - Single window as described above.
  - No accumulator logic is present.

## Test plan
- GATE_CYCLES=100, SETTLE_CYCLES=4, Tout period 10 Clk (toggle every 5), one Start pulse.
  - Count=10, Overflow=0.
  - Valid is a single cycle, 105 cycles after the Start sample.
  - OscEn is high for cycles 1–104.
- CNT_W=4, GATE_CYCLES=100, Tout period 4 Clk.
  - Count=15 and Overflow=1.
  - Next run with Tout period 20: Count=5, Overflow=0.
- Tout held at 0 → Count=0 and Valid still asserted on schedule.
- Reset pulsed at cycle 50 of MEASURE.
  - Next cycle: OscEn=0, Busy=0, Count is the prior value (0 after reset), and no Valid.
  - A subsequent Start produces a correct count.
- Start held high for 400 cycles with GATE_CYCLES=100, SETTLE_CYCLES=4.
  - Valid pulses are 106 cycles apart.
  - Start pulses during Busy create no extra measurements.
- With OSC_METER_AVG_EN, windows with Tout periods giving 10, 10, 11, 12 edges → Count=10 (43>>2), with Valid at SETTLE_CYCLES+4·GATE_CYCLES+1.
